vga_timing_gen: RTL and testbench

Parametrised VGA timing generator. It is the successor to the fixed 640x480 driver and sits between the pixel source (frame buffer or pattern logic) and the VGA DAC pins. Every timing value, the sync polarities, the coordinate widths and the pixel-source fetch latency are parameters. A clock-enable lets it run from a faster system clock. Line-start and frame-start strobes drive downstream logic.

---
 rtl/vga_timing_if.sv | 25 ++
 rtl/vga_timing_gen.sv | 98 +++++++++
 tb/tb_vga_timing_gen.sv | 129 ++++++++++++
 3 files changed

// File: rtl/vga_timing_if.sv
// vga_timing_if: pixel-side bundle between the timing generator, its pixel source and the DAC
interface vga_timing_if #(
  parameter int COLOR_W = 12,
  parameter int X_W = 10,
  parameter int Y_W = 10
);
  logic ce;
  logic [COLOR_W-1:0] pixelIn;
  logic [COLOR_W-1:0] pixelOut;
  logic Hsync;
  logic Vsync;
  logic de;
  logic [X_W-1:0] posX;
  logic [Y_W-1:0] posY;
  logic line_start;
  logic frame_start;
  modport master (
    input ce, pixelIn,
    output pixelOut, Hsync, Vsync, de, posX, posY, line_start, frame_start
  );
  modport slave (
    output ce, pixelIn,
    input pixelOut, Hsync, Vsync, de, posX, posY, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA sync/blanking generator with pixel-source latency alignment
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT = 16,
  parameter int H_SYNC = 96,
  parameter int H_BACK = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT = 10,
  parameter int V_SYNC = 2,
  parameter int V_BACK = 33,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int COLOR_W = 12,
  parameter int PIPE_LAT = 2,
  parameter int X_W = 10,
  parameter int Y_W = 10
) (
  input logic clk,
  input logic rst,
  vga_timing_if.master bus
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [X_W-1:0] H_LAST = X_W'(H_TOTAL - 1);
  localparam logic [X_W-1:0] H_VIS = X_W'(H_VISIBLE);
  localparam logic [X_W-1:0] HS_BEG = X_W'(H_VISIBLE + H_FRONT);
  localparam logic [X_W-1:0] HS_END = X_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [Y_W-1:0] V_LAST = Y_W'(V_TOTAL - 1);
  localparam logic [Y_W-1:0] V_VIS = Y_W'(V_VISIBLE);
  localparam logic [Y_W-1:0] VS_BEG = Y_W'(V_VISIBLE + V_FRONT);
  localparam logic [Y_W-1:0] VS_END = Y_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic H_IDLE = HSYNC_POL == 0;
  localparam logic V_IDLE = VSYNC_POL == 0;
  if (H_TOTAL > (1 << X_W) || V_TOTAL > (1 << Y_W)) begin : g_bad_width
    $error("vga_timing_gen: X_W/Y_W too narrow for the frame totals");
  end
  if (PIPE_LAT < 0 || PIPE_LAT > 4) begin : g_bad_lat
    $error("vga_timing_gen: PIPE_LAT must be 0..4");
  end
  logic [X_W-1:0] hcnt;
  logic [Y_W-1:0] vcnt;
  logic hwrap;
  logic [4:0] fl;
  logic [4:0] fd;
  assign hwrap = hcnt == H_LAST;
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (bus.ce) begin
      hcnt <= hwrap ? '0 : hcnt + 1'b1;
      if (hwrap) vcnt <= vcnt == V_LAST ? '0 : vcnt + 1'b1;
    end
  end
  // flag vector order: {vis, hs, vs, ls, fs}
  assign fl = {
    hcnt < H_VIS && vcnt < V_VIS,
    hcnt >= HS_BEG && hcnt <= HS_END,
    vcnt >= VS_BEG && vcnt <= VS_END,
    hcnt == '0 && vcnt < V_VIS,
    hcnt == '0 && vcnt == '0
  };
  if (PIPE_LAT == 0) begin : g_nopipe
    assign fd = fl;
  end else begin : g_pipe
    logic [PIPE_LAT-1:0][4:0] pipe;
    always_ff @(posedge clk) begin
      if (rst) pipe <= '0;
      else if (bus.ce) begin
        pipe[0] <= fl;
        for (int i = 1; i < PIPE_LAT; i++) pipe[i] <= pipe[i-1];
      end
    end
    assign fd = pipe[PIPE_LAT-1];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.pixelOut <= '0;
      bus.de <= 1'b0;
      bus.Hsync <= H_IDLE;
      bus.Vsync <= V_IDLE;
      bus.line_start <= 1'b0;
      bus.frame_start <= 1'b0;
    end else begin
      if (bus.ce) begin
        bus.de <= fd[4];
        bus.pixelOut <= fd[4] ? bus.pixelIn : '0;
        bus.Hsync <= fd[3] ^ H_IDLE;
        bus.Vsync <= fd[2] ^ V_IDLE;
      end
      // strobes are one clk wide even when ce is held for several clks
      bus.line_start <= bus.ce & fd[1];
      bus.frame_start <= bus.ce & fd[0];
    end
  end
  assign bus.posX = hcnt;
  assign bus.posY = vcnt;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: three generator configurations checked every clk against an index-based timing model
module tb_vga_timing_gen;
  typedef struct {
    int hv, hf, hs, hb, vv, vf, vs, vb;
    bit hp, vp;
    int lat;
  } cfg_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  cfg_t cfg [3];
  int n [3];
  bit ce [3];
  vga_timing_if #(.COLOR_W(12), .X_W(10), .Y_W(10)) b0 ();
  vga_timing_if #(.COLOR_W(12), .X_W(6), .Y_W(5)) b1 ();
  vga_timing_if #(.COLOR_W(12), .X_W(4), .Y_W(3)) b2 ();
  vga_timing_gen u0 (.clk(clk), .rst(rst), .bus(b0));
  vga_timing_gen #(
    .H_VISIBLE(40), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
    .V_VISIBLE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .X_W(6), .Y_W(5)
  ) u1 (.clk(clk), .rst(rst), .bus(b1));
  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HSYNC_POL(1), .VSYNC_POL(1), .PIPE_LAT(0), .X_W(4), .Y_W(3)
  ) u2 (.clk(clk), .rst(rst), .bus(b2));
  always #5 clk = ~clk;
  task automatic check(string tag, logic [48:0] got, logic [48:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [11:0] pat_at(cfg_t c, int j);
    int ht, vt;
    ht = c.hv + c.hf + c.hs + c.hb;
    vt = c.vv + c.vf + c.vs + c.vb;
    return 12'(((j / ht) % vt % 16) * 256 + (j % ht) % 256);
  endfunction
  // expected pins after n ce ticks since reset; tick says whether this clk consumed one
  function automatic logic [48:0] model(cfg_t c, int cnt, bit tick);
    int ht, vt, j, x, y;
    logic vis, hs, vs, ls, fs;
    logic [11:0] pix;
    ht = c.hv + c.hf + c.hs + c.hb;
    vt = c.vv + c.vf + c.vs + c.vb;
    j = cnt - c.lat - 1;
    {vis, hs, vs, ls, fs} = '0;
    pix = '0;
    if (j >= 0) begin
      x = j % ht;
      y = (j / ht) % vt;
      vis = x < c.hv && y < c.vv;
      hs = x >= c.hv + c.hf && x < c.hv + c.hf + c.hs;
      vs = y >= c.vv + c.vf && y < c.vv + c.vf + c.vs;
      ls = tick && x == 0 && y < c.vv;
      fs = tick && x == 0 && y == 0;
      pix = vis ? pat_at(c, j) : 12'd0;
    end
    return {16'((cnt / ht) % vt), 16'(cnt % ht), pix, vis,
            hs ? c.hp : !c.hp, vs ? c.vp : !c.vp, ls, fs};
  endfunction
  function automatic logic [48:0] act(int d);
    return d == 0 ? {16'(b0.posY), 16'(b0.posX), b0.pixelOut, b0.de, b0.Hsync, b0.Vsync, b0.line_start, b0.frame_start}
         : d == 1 ? {16'(b1.posY), 16'(b1.posX), b1.pixelOut, b1.de, b1.Hsync, b1.Vsync, b1.line_start, b1.frame_start}
         :          {16'(b2.posY), 16'(b2.posX), b2.pixelOut, b2.de, b2.Hsync, b2.Vsync, b2.line_start, b2.frame_start};
  endfunction
  initial begin
    int last0, last1, last2, ph, lph1;
    logic [11:0] pin;
    cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 2};
    cfg[1] = '{40, 4, 6, 6, 12, 2, 2, 3, 1'b0, 1'b0, 2};
    cfg[2] = '{8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b1, 0};
    n = '{0, 0, 0};
    ce = '{1'b1, 1'b1, 1'b1};
    {b0.ce, b1.ce, b2.ce} = 3'b111;
    b0.pixelIn = 12'($urandom);
    b1.pixelIn = 12'($urandom);
    b2.pixelIn = 12'($urandom);
    last0 = -1;
    last1 = -1;
    last2 = -1;
    lph1 = 0;
    for (int cyc = 0; cyc < 14000; cyc++) begin
      @(posedge clk);
      #1;
      ph = cyc < 3000 ? 0 : cyc < 9000 ? 1 : 2;
      for (int d = 0; d < 3; d++) begin
        n[d] = rst ? 0 : n[d] + (ce[d] ? 1 : 0);
        check($sformatf("pins dut%0d cyc%0d", d, cyc), act(d), model(cfg[d], n[d], ce[d] && !rst));
      end
      if (rst) begin
        check("rst_state", {16'(b0.posX), 16'(b0.posY), b0.pixelOut, b0.de, b0.Hsync, b0.Vsync},
              {32'd0, 12'd0, 1'b0, 1'b1, 1'b1});
        last0 = -1;
        last1 = -1;
        last2 = -1;
      end
      if (b0.line_start) begin
        if (last0 >= 0) check("line_period_default", 49'(cyc - last0), 49'd800);
        last0 = cyc;
      end
      if (b1.frame_start) begin
        if (last1 >= 0 && ph == lph1 && ph < 2)
          check($sformatf("frame_period_mid_ph%0d", ph), 49'(cyc - last1), ph == 0 ? 49'd1064 : 49'd2128);
        last1 = cyc;
        lph1 = ph;
      end
      if (b2.frame_start) begin
        if (last2 >= 0) check("frame_period_small", 49'(cyc - last2), 49'd98);
        last2 = cyc;
      end
      rst = cyc < 1 || cyc == 4000;
      ce[1] = ph == 0 ? 1'b1 : ph == 1 ? bit'(cyc % 2 == 0) : bit'($urandom_range(0, 1));
      b1.ce = ce[1];
      for (int d = 0; d < 3; d++) begin
        pin = (ce[d] && !rst && n[d] >= cfg[d].lat) ? pat_at(cfg[d], n[d] - cfg[d].lat) : 12'($urandom);
        if (d == 0) b0.pixelIn = pin;
        else if (d == 1) b1.pixelIn = pin;
        else b2.pixelIn = pin;
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
